// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender behind a valid/ready
// handshake, with a 2-entry output FIFO so in_ready is purely registered.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand/mode valid this cycle
//   in_ready   block accepts input this cycle (count != 2)
//   operand    raw IN_W-bit immediate
//   mode       00 zero-ext, 01 sign-ext, 10 upper-place, 11 sign-ext << 2
//   out_valid  ext_val holds a valid result (count != 0)
//   out_ready  consumer accepts ext_val this cycle
//   ext_val    OUT_W-bit result at the buffer head
//   occupancy  number of buffered results, 0..2
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  operand,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext_val,
    output logic [1:0]       occupancy
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] zext_w;
    logic [OUT_W-1:0] sext_w;
    logic [OUT_W-1:0] upper_w;
    logic [OUT_W-1:0] shl2_w;
    logic [OUT_W-1:0] res_w;

    logic [OUT_W-1:0] mem_q [2];
    logic             head_q;
    logic             head_d;
    logic             tail_q;
    logic             tail_d;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    logic push;
    logic pop;

    assign zext_w  = {{PAD_W{1'b0}}, operand};
    assign sext_w  = {{PAD_W{operand[IN_W-1]}}, operand};
    assign upper_w = {operand, {PAD_W{1'b0}}};
    // Branch offset: top two sign bits fall off, truncation is intended.
    assign shl2_w  = {sext_w[OUT_W-3:0], 2'b00};

    always_comb begin
        res_w = zext_w;
        unique case (mode)
            2'b00: res_w = zext_w;
            2'b01: res_w = sext_w;
            2'b10: res_w = upper_w;
            2'b11: res_w = shl2_w;
            default: res_w = zext_w;
        endcase
    end

    // Both flags come straight from count_q; no path from out_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign occupancy = count_q;
    assign ext_val   = mem_q[head_q];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push) begin
            mem_q[tail_q] <= res_w;
        end
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, registered successor to the combinational 16-to-32 sign extender.
- Widens an IN_W-bit immediate to OUT_W bits in one of four modes: zero-extend, sign-extend, upper-place (LUI) and sign-extend shifted left by 2 (branch offset).
- Sits between decode and the execute operand mux, behind a valid/ready handshake.
- Carries a 2-entry output buffer so that `in_ready` depends only on registered state, not on `out_ready`.

Parameters:
- IN_W, 16, immediate input width; must be ≥ 2.
- OUT_W, 32, extended output width; must be ≥ IN_W + 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand/mode valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- operand  input  IN_W  raw immediate.
- mode  input  2  00 zero-ext, 01 sign-ext, 10 upper-place, 11 sign-ext then shift left 2.
- out_valid  output  1  ext_val holds a valid result.
- out_ready  input  1  consumer accepts ext_val this cycle.
- ext_val  output  OUT_W  extended result at the buffer head.
- occupancy  output  2  number of buffered results, 0..2.

Behaviour:
- Extension function, combinational on the input side:
  - mode 00: OUT_W−IN_W zeros, then operand.
  - mode 01: OUT_W−IN_W copies of operand[IN_W−1], then operand.
  - mode 10: operand in bits [OUT_W−1 : OUT_W−IN_W], zeros below.
  - mode 11: the mode-01 value shifted left 2, top 2 bits discarded, bits [1:0] = 0.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - A result is written to the buffer on the push edge.
  - Latency 1 cycle: a result pushed at edge N is visible at the head after N if the buffer was empty.
- Buffer:
  - 2-entry FIFO, registered storage, head/tail pointers each 1 bit, plus a 2-bit count.
  - in_ready = (count != 2), registered-state only.
  - out_valid = (count != 0).
  - ext_val = storage[head]; hold last head value when empty; value is don't-care for checking when out_valid = 0.
- Simultaneous events:
  - push & pop: count unchanged; both pointers advance.
  - push & pop at count 0 is impossible, since out_valid = 0.
  - At count 2 no push occurs; a pop drops count to 1 and in_ready rises the next cycle, with no same-cycle combinational path.
- Ordering: strict FIFO; results leave in acceptance order.
- Stability: while out_valid = 1 and out_ready = 0, ext_val must not change.
- Input protocol: operand and mode are sampled only on push; their values when in_valid = 0 are ignored.
- Reset (asynchronous, any time, including mid-transfer):
  - count = 0, head = 0, tail = 0, out_valid = 0, occupancy = 0, storage = 0, ext_val = 0, in_ready = 1.
  - Buffered entries are discarded.
  - The first push after deassertion is handled normally.
- occupancy = count.
- No error or overflow outputs: truncation in mode 11 is intended behaviour.

Test Plan:
- Mode sweep at defaults, out_ready = 1:
  - operand 0x8001 mode 00 → 0x00008001.
  - operand 0x8001 mode 01 → 0xFFFF8001.
  - operand 0x1234 mode 10 → 0x12340000.
  - operand 0xFFFF mode 11 → 0xFFFFFFFC.
  - operand 0x4000 mode 11 → 0x00010000.
  - Each result appears one cycle after its push.
- Backpressure:
  - Hold out_ready = 0 and push 0x0001, 0x0002, 0x0003 (mode 01).
  - Required: first two accepted, occupancy = 2, in_ready = 0 on the third, ext_val holds 0x00000001.
  - Release out_ready: outputs are 0x00000001 then 0x00000002; the third is accepted one cycle after the first pop.
- Streaming: continuous in_valid and out_ready = 1 for 16 operands → one result per cycle, occupancy steady at 1, order preserved.
- Simultaneous push/pop at count 1 → count stays 1 and the data sequence is correct.
- Async reset:
  - Assert rst mid-clock with occupancy = 2 → out_valid = 0, in_ready = 1, occupancy = 0 immediately, without waiting for a clock edge.
  - After release, push 0x7FFF mode 01 → 0x00007FFF.
- Parameter variant IN_W = 8, OUT_W = 16:
  - operand 0x80 mode 01 → 0xFF80.
  - operand 0x80 mode 10 → 0x8000.
  - operand 0xC0 mode 11 → 0xFF00.
